stdp_wb_sched: RTL and testbench
================================

STDP_WB_SCHED -- requirements
Module: stdp_wb_sched

Interface
REQ-001 SHALL have parameter F, default 48, number of input features (pre-synaptic rows).
REQ-002 SHALL have parameter N, default 96, number of neurons (post-synaptic columns).
REQ-003 SHALL have parameter AW, default (F*N<=1)?1:$clog2(F*N), weight address width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to run one STDP write-back sweep.
REQ-007 SHALL have port pre_bits  input  F  pre-synaptic spike bits, sampled at accepted start.
REQ-008 SHALL have port post_bits  input  N  post-synaptic spike bits, sampled at accepted start.
REQ-009 SHALL have port eta  input  16 signed  learning rate, Q1.14, sampled at accepted start.
REQ-010 SHALL have port eta_shift  input  8  right-shift applied to eta, sampled at accepted start.
REQ-011 SHALL have port wmin / wmax  input  16 signed each  Q1.14 clamp bounds, sampled at accepted start.
REQ-012 SHALL have port enable_pre / enable_post  input  1 each  LTP / LTD enables, sampled at accepted start.
REQ-013 SHALL have port busy  output  1  high from the cycle after accepted start until done.
REQ-014 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-015 SHALL have port w_re  output  1  weight read strobe.
REQ-016 SHALL have port w_addr  output  AW  weight address, addr = f*N + n.
REQ-017 SHALL have port w_rdata  input  16 signed  weight read data, valid the cycle after w_re.
REQ-018 SHALL have port w_we / w_wdata  output  1 / 16 signed  weight write strobe and data.
REQ-019 SHALL have port upd_count  output  AW+1  number of writes whose value differed from rdata in last sweep.

Function
REQ-020 FSM states SHALL be IDLE, READ, CALC, WRITE, DONE.
REQ-021 IDLE: start=1 SHALL latch all sampled inputs, clear addr and upd_count, go READ; start while not IDLE SHALL be ignored.
REQ-022 READ SHALL assert w_re=1 with w_addr=current addr for exactly one cycle, then go CALC.
REQ-023 CALC SHALL register w_rdata and the computed new weight, then go WRITE.
REQ-024 WRITE SHALL assert w_we=1 with w_wdata=new weight and unchanged w_addr; addr==F*N-1 -> DONE, else addr+1 -> READ.
REQ-025 DONE SHALL pulse done=1 for one cycle and return to IDLE; busy=0 in DONE.
REQ-026 Step SHALL be eta >>> eta_shift (arithmetic); eta_shift>=16 SHALL give step = (eta<0 ? -1 : 0).
REQ-027 Update SHALL be: pre[f]&post[n]&enable_pre -> w+step; !pre[f]&post[n]&enable_post -> w-step; else w unchanged.
REQ-028 Sum SHALL be computed in 18-bit signed, then clamped to [wmin,wmax]; if wmin>wmax, result SHALL be wmin.
REQ-029 f = addr / N, n = addr % N, derived from counters (f,n) incremented n-first, not by division.
REQ-030 upd_count SHALL increment in WRITE when w_wdata != registered rdata; it SHALL hold after DONE until next accepted start.
REQ-031 w_re and w_we SHALL never be asserted in the same cycle; w_we SHALL be 0 outside WRITE, w_re 0 outside READ.
REQ-032 Latency without skip: start accepted at cycle 0 -> done at cycle 3*F*N+1.

Reset
REQ-033 rstn=0 at posedge SHALL force IDLE, busy=0, done=0, w_re=0, w_we=0, w_addr=0, w_wdata=0, upd_count=0.
REQ-034 Reset mid-sweep SHALL abort with no further read/write; already-written weights are not restored.

Configuration
REQ-035 Macro STDP_WB_SKIP_EN defined: in READ, if post[n]==0 the address SHALL advance in one cycle with w_re=0 and no write; last address -> DONE.
REQ-036 Macro STDP_WB_SKIP_EN undefined: every address SHALL be read and written (REQ-022..024), unchanged values included.

Verification
REQ-037 F=2,N=2, pre=2'b01, post=2'b01, eta=16384, shift=4, w[all]=0, wmin=-16384, wmax=16384 -> w[0]=1024, others written 0 (no skip); w[2]=-1024 if enable_post; done at cycle 13; upd_count=2.
REQ-038 w[0]=16000, same LTP step 1024, wmax=16384 -> w_wdata=16384 (clamp); wmin=-16384, w=-16000, LTD -> -16384.
REQ-039 start pulsed again while busy -> ignored; single done pulse; write count = F*N.
REQ-040 rstn=0 during WRITE of addr 1 -> no further w_re/w_we, busy=0, done never pulses; next start runs full sweep from addr 0.
REQ-041 STDP_WB_SKIP_EN, post=2'b00 -> zero w_re/w_we, done at cycle F*N+1, upd_count=0.
REQ-042 eta_shift=20, eta=-5 -> step=-1; LTP on w=0 -> w_wdata=-1.

Source files
------------

// File: rtl/stdp_wb_sched.sv
// rtl/stdp_wb_sched.sv - STDP weight write-back sweep: read, update, clamp and write every (f,n) weight.
// Optional STDP_WB_SKIP_EN: columns with no post spike are stepped over without a read or write.
module stdp_wb_sched #(
  parameter int F  = 48,
  parameter int N  = 96,
  parameter int AW = (F*N <= 1) ? 1 : $clog2(F*N)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [F-1:0]       pre_bits,
  input  logic [N-1:0]       post_bits,
  input  logic signed [15:0] eta,
  input  logic [7:0]         eta_shift,
  input  logic signed [15:0] wmin,
  input  logic signed [15:0] wmax,
  input  logic               enable_pre,
  input  logic               enable_post,
  output logic               busy,
  output logic               done,
  output logic               w_re,
  output logic [AW-1:0]      w_addr,
  input  logic signed [15:0] w_rdata,
  output logic               w_we,
  output logic signed [15:0] w_wdata,
  output logic [AW:0]        upd_count
);
  localparam int FW = (F <= 1) ? 1 : $clog2(F);
  localparam int NW = (N <= 1) ? 1 : $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(F*N-1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_DONE} state_t;

  state_t             r_state;
  logic [F-1:0]       r_pre;
  logic [N-1:0]       r_post;
  logic signed [15:0] r_step, r_wmin, r_wmax, r_rdata;
  logic               r_en_pre, r_en_post;
  logic [FW-1:0]      r_f;
  logic [NW-1:0]      r_n;

  logic [NW-1:0]      w_n_next;
  logic [FW-1:0]      w_f_next;
  logic               w_skip, w_adv, w_ltp, w_ltd;
  logic signed [17:0] w_step18, w_sum, w_min18, w_max18;
  logic signed [15:0] w_new;

  always_comb begin
    w_n_next = (r_n == NW'(N-1)) ? '0 : r_n + 1'b1;
    w_f_next = (r_n == NW'(N-1)) ? r_f + 1'b1 : r_f;
`ifdef STDP_WB_SKIP_EN
    w_skip   = (r_state == S_READ) && !r_post[r_n];
`else
    w_skip   = 1'b0;
`endif
    w_adv    = (r_state == S_WRITE) || w_skip;
    w_ltp    = r_pre[r_f] & r_post[r_n] & r_en_pre;
    w_ltd    = !r_pre[r_f] & r_post[r_n] & r_en_post;
    w_step18 = {{2{r_step[15]}}, r_step};
    w_min18  = {{2{r_wmin[15]}}, r_wmin};
    w_max18  = {{2{r_wmax[15]}}, r_wmax};
    // 18 bits hold w +/- step without wrap, even for step = -32768
    w_sum    = {{2{w_rdata[15]}}, w_rdata} + (w_ltp ? w_step18 : (w_ltd ? -w_step18 : 18'sd0));
    if (r_wmin > r_wmax)      w_new = r_wmin;
    else if (w_sum < w_min18) w_new = r_wmin;
    else if (w_sum > w_max18) w_new = r_wmax;
    else                      w_new = w_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_re      <= 1'b0;
      w_we      <= 1'b0;
      w_addr    <= '0;
      w_wdata   <= '0;
      upd_count <= '0;
      r_f       <= '0;
      r_n       <= '0;
    end else begin
      done <= 1'b0;
      w_re <= 1'b0;
      w_we <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_pre     <= pre_bits;
          r_post    <= post_bits;
          r_wmin    <= wmin;
          r_wmax    <= wmax;
          r_en_pre  <= enable_pre;
          r_en_post <= enable_post;
          if (eta_shift >= 8'd16) r_step <= eta[15] ? -16'sd1 : 16'sd0;
          else                    r_step <= eta >>> eta_shift[3:0];
          w_addr    <= '0;
          r_f       <= '0;
          r_n       <= '0;
          upd_count <= '0;
          busy      <= 1'b1;
          r_state   <= S_READ;
`ifdef STDP_WB_SKIP_EN
          w_re      <= post_bits[0];
`else
          w_re      <= 1'b1;
`endif
        end
        S_READ:  if (!w_skip) r_state <= S_CALC;
        S_CALC: begin
          r_rdata <= w_rdata;
          w_wdata <= w_new;
          w_we    <= 1'b1;
          r_state <= S_WRITE;
        end
        S_WRITE: if (w_wdata != r_rdata) upd_count <= upd_count + 1'b1;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // w_re is registered, so the read strobe for the next address is decided here
      if (w_adv) begin
        if (w_addr == LAST) begin
          r_state <= S_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end else begin
          w_addr  <= w_addr + 1'b1;
          r_n     <= w_n_next;
          r_f     <= w_f_next;
          r_state <= S_READ;
`ifdef STDP_WB_SKIP_EN
          w_re    <= r_post[w_n_next];
`else
          w_re    <= 1'b1;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_stdp_wb_sched.sv
// tb/tb_stdp_wb_sched.sv - scoreboard bench for stdp_wb_sched with a behavioural weight-update model.
module tb_stdp_wb_sched;
  localparam int F  = 3;
  localparam int N  = 4;
  localparam int FN = F*N;
  localparam int AW = $clog2(FN);
`ifdef STDP_WB_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0, start = 1'b0;
  logic [F-1:0] pre_bits = '0;
  logic [N-1:0] post_bits = '0;
  logic signed [15:0] eta = '0, wmin = '0, wmax = '0, w_rdata, w_wdata;
  logic [7:0] eta_shift = '0;
  logic enable_pre = 1'b0, enable_post = 1'b0;
  logic busy, done, w_re, w_we;
  logic [AW-1:0] w_addr;
  logic [AW:0] upd_count;

  stdp_wb_sched #(.F(F), .N(N)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .pre_bits(pre_bits), .post_bits(post_bits),
    .eta(eta), .eta_shift(eta_shift), .wmin(wmin), .wmax(wmax),
    .enable_pre(enable_pre), .enable_post(enable_post), .busy(busy), .done(done),
    .w_re(w_re), .w_addr(w_addr), .w_rdata(w_rdata), .w_we(w_we), .w_wdata(w_wdata),
    .upd_count(upd_count)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  wr_t e;
  int n_checks = 0, n_err = 0;
  int cyc = 0, t0 = 0, exp_lat = 0, exp_upd = 0, exp_reads = 0;
  int n_rd = 0, n_wr = 0, n_done = 0, rd0 = 0, wr0 = 0, dn0 = 0;
  logic signed [15:0] mem [16];
  logic signed [15:0] ld_mem [16];
  logic ld = 1'b0;
  int ref_mem [FN];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // weight memory: one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld) for (int i = 0; i < FN; i++) mem[i] <= ld_mem[i];
    else if (w_we) mem[w_addr] <= w_wdata;
    if (w_re) w_rdata <= mem[w_addr];
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (w_re) n_rd <= n_rd + 1;
      if (w_re && w_we) chk("re_we_exclusive", 1, 0);
      if (w_we) begin
        n_wr <= n_wr + 1;
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("w_addr", w_addr, e.addr);
          chk("w_wdata", w_wdata, e.data);
        end
      end
      if (done) begin
        n_done <= n_done + 1;
        chk("done_latency", cyc - t0, exp_lat);
        chk("upd_count_at_done", upd_count, exp_upd);
        chk("busy_in_done", busy, 0);
      end
    end
  end

  task automatic load_mem();
    for (int i = 0; i < FN; i++) ref_mem[i] = ld_mem[i];
    @(negedge clk); ld = 1'b1;
    @(negedge clk); ld = 1'b0;
  endtask

  task automatic clear_ld();
    for (int i = 0; i < FN; i++) ld_mem[i] = 16'sd0;
  endtask

  // model the sweep from the update rules, then accept the start
  task automatic issue(input logic [F-1:0] pre, input logic [N-1:0] post, input int eta_v,
                       input int sh, input int lo, input int hi, input bit ep, input bit eo);
    int step, d, w, res, lat, reads, upd, f, n;
    if (sh >= 16) step = (eta_v < 0) ? -1 : 0;
    else begin
      step = eta_v / (1 << sh);
      if (eta_v < 0 && (eta_v % (1 << sh)) != 0) step = step - 1;
    end
    lat = 1; reads = 0; upd = 0;
    for (int a = 0; a < FN; a++) begin
      f = a / N; n = a % N;
      if (SKIP && !post[n]) lat = lat + 1;
      else begin
        lat = lat + 3; reads++;
        w = ref_mem[a];
        if (pre[f] && post[n] && ep) d = step;
        else if (!pre[f] && post[n] && eo) d = -step;
        else d = 0;
        res = w + d;
        if (lo > hi) res = lo;
        else if (res < lo) res = lo;
        else if (res > hi) res = hi;
        if (res != w) upd++;
        ref_mem[a] = res;
        exp_q.push_back('{a, res});
      end
    end
    @(negedge clk);
    pre_bits = pre; post_bits = post; eta = 16'(eta_v); eta_shift = 8'(sh);
    wmin = 16'(lo); wmax = 16'(hi); enable_pre = ep; enable_post = eo; start = 1'b1;
    exp_lat = lat; exp_upd = upd; exp_reads = reads;
    t0 = cyc; rd0 = n_rd; wr0 = n_wr; dn0 = n_done;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_sweep(input bit restart);
    int k;
    if (restart) begin
      repeat (4) @(negedge clk);
      pre_bits = ~pre_bits; post_bits = ~post_bits; eta = 16'sd9999; eta_shift = 8'd0; start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    k = 0;
    while (n_done == dn0 && k < exp_lat + 20) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    chk("done_pulses", n_done - dn0, 1);
    chk("read_count", n_rd - rd0, exp_reads);
    chk("write_count", n_wr - wr0, exp_reads);
    chk("upd_count_hold", upd_count, exp_upd);
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    for (int a = 0; a < FN; a++) chk($sformatf("mem[%0d]", a), mem[a], ref_mem[a]);
    for (int a = 0; a < FN; a++) ref_mem[a] = mem[a];
  endtask

  initial begin
    int eta_v, sh, lo, hi, tmp, k;
    logic signed [15:0] r16;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_w_re", w_re, 0);
    chk("rst_w_we", w_we, 0); chk("rst_w_addr", w_addr, 0); chk("rst_w_wdata", w_wdata, 0);
    chk("rst_upd_count", upd_count, 0);
    rstn = 1'b1;

    clear_ld(); load_mem();
    issue(3'b001, 4'b0001, 16384, 4, -16384, 16384, 1'b1, 1'b0); finish_sweep(1'b0);
    chk("ltp_w0", mem[0], 1024); chk("ltp_upd", upd_count, 1);

    clear_ld(); load_mem();
    issue(3'b001, 4'b0001, 16384, 4, -16384, 16384, 1'b1, 1'b1); finish_sweep(1'b0);
    chk("ltd_w4", mem[4], -1024); chk("ltd_w8", mem[8], -1024); chk("ltd_upd", upd_count, 3);

    clear_ld(); ld_mem[0] = 16'sd16000; ld_mem[4] = -16'sd16000; load_mem();
    issue(3'b001, 4'b0001, 16384, 4, -16384, 16384, 1'b1, 1'b1); finish_sweep(1'b0);
    chk("clamp_hi", mem[0], 16384); chk("clamp_lo", mem[4], -16384);

    clear_ld(); load_mem();
    issue(3'b001, 4'b0001, -5, 20, -16384, 16384, 1'b1, 1'b0); finish_sweep(1'b0);
    chk("big_shift_neg", mem[0], -1);

    issue(3'b101, 4'b1111, 3000, 2, 100, -100, 1'b1, 1'b1); finish_sweep(1'b0);
    chk("wmin_gt_wmax", mem[5], 100);

    issue(3'b111, 4'b0000, 4000, 1, -30000, 30000, 1'b1, 1'b1); finish_sweep(1'b1);
    issue(3'b010, 4'b0110, 8000, 3, -30000, 30000, 1'b1, 1'b1); finish_sweep(1'b1);

    // abort during the write of address 1
    issue(3'b011, 4'b1011, 8000, 2, -30000, 30000, 1'b1, 1'b1);
    k = 0;
    while (!(w_we && w_addr == 1) && k < 40) begin @(negedge clk); k++; end
    chk("reached_write_addr1", k < 40, 1);
    rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    exp_q.delete();
    repeat (10) begin
      @(negedge clk);
      chk("abort_quiet", {busy, done, w_re, w_we}, 0);
    end
    chk("abort_no_done", n_done - dn0, 0);
    for (int a = 0; a < FN; a++) ref_mem[a] = mem[a];
    issue(3'b110, 4'b1101, 6000, 1, -30000, 30000, 1'b1, 1'b1); finish_sweep(1'b0);

    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < FN; i++) ld_mem[i] = 16'($urandom);
      load_mem();
      r16 = 16'($urandom); eta_v = r16;
      sh = $urandom_range(0, 20);
      r16 = 16'($urandom); lo = r16;
      r16 = 16'($urandom); hi = r16;
      if (lo > hi && $urandom_range(0, 3) != 0) begin tmp = lo; lo = hi; hi = tmp; end
      issue(F'($urandom), N'($urandom), eta_v, sh, lo, hi, 1'($urandom), 1'($urandom));
      finish_sweep(1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
